// File: rtl/ex_muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface ex_muldiv_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] reg_1;
  logic [XLEN-1:0] reg_2;
  logic [4:0]      waddr_i;
  logic            we_i;
  logic            flush_i;
  logic            stall_o;
  logic            valid_o;
  logic [XLEN-1:0] wdata_o;
  logic [4:0]      waddr_o;
  logic            we_o;

  modport master (
    output start_i, op_i, reg_1, reg_2, waddr_i, we_i, flush_i,
    input  stall_o, valid_o, wdata_o, waddr_o, we_o
  );

  modport slave (
    input  start_i, op_i, reg_1, reg_2, waddr_i, we_i, flush_i,
    output stall_o, valid_o, wdata_o, waddr_o, we_o
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction folded into the final step.
module ex_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_iter_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULH  = 3'b001;
  localparam logic [2:0] OP_MULHU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_REM   = 3'b101;
  localparam logic [2:0] OP_REMU  = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              we_q, we_d;
  logic              stall_c;

  // Incoming operand decode: signedness, magnitudes and the final sign flag.
  logic            div_in, sgn_in, neg_in;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    div_in = (bus.op_i >= OP_DIV) && (bus.op_i != OP_RSV);
    sgn_in = (bus.op_i == OP_MUL) || (bus.op_i == OP_MULH) ||
             (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    mag_a  = (sgn_in && bus.reg_1[XLEN-1]) ? -bus.reg_1 : bus.reg_1;
    mag_b  = (sgn_in && bus.reg_2[XLEN-1]) ? -bus.reg_2 : bus.reg_2;
    if (bus.op_i == OP_REM) neg_in = bus.reg_1[XLEN-1];
    else if (sgn_in)        neg_in = bus.reg_1[XLEN-1] ^ bus.reg_2[XLEN-1];
    else                    neg_in = 1'b0;
  end

  // One iteration: acc is {hi, lo}; multiply adds a_q into hi and shifts right,
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  logic            is_div_q;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [PW-1:0]   step, prod_fix;
  logic [XLEN-1:0] q_fix, r_fix, result;

  always_comb begin
    is_div_q = (op_q >= OP_DIV);
    mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    div_sh   = acc_q[PW-1:XLEN-1];
    div_diff = div_sh - {1'b0, b_q};
    if (is_div_q)
      step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      step = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = neg_q ? -step : step;
    q_fix    = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    r_fix    = neg_q ? -step[PW-1:XLEN] : step[PW-1:XLEN];
    case (op_q)
      OP_MUL:            result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU: result = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:   result = q_fix;
      OP_REM, OP_REMU:   result = r_fix;
      default:           result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state, datapath load/step and the combinational stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          stall_c = 1'b1;
          op_d    = bus.op_i;
          waddr_d = bus.waddr_i;
          we_d    = bus.we_i;
          if (bus.op_i == OP_RSV) begin
            wdata_d = '0;
            state_d = DONE;
          end else if (div_in && (bus.reg_2 == '0)) begin
            wdata_d = ((bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU)) ? '1 : bus.reg_1;
            state_d = DONE;
          end else begin
            a_d     = mag_a;
            b_d     = mag_b;
            neg_d   = neg_in;
            acc_d   = {{XLEN{1'b0}}, (div_in ? mag_a : mag_b)};
            cnt_d   = CNT_W'(XLEN);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stall_c = 1'b1;
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            wdata_d = result;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        stall_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // A flush landing in DONE kills the strobe in the same cycle.
  assign bus.stall_o = stall_c;
  assign bus.valid_o = (state_q == DONE) && !bus.flush_i;
  assign bus.we_o    = we_q && bus.valid_o;
  assign bus.wdata_o = wdata_q;
  assign bus.waddr_o = waddr_q;
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed bench for ex_muldiv_iter: XLEN=32 instance for all ops/flush/reset, XLEN=16 for width scaling.
module tb_ex_muldiv_iter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  ex_muldiv_iter_if #(.XLEN(32)) bus ();
  ex_muldiv_iter_if #(.XLEN(16)) bus16 ();

  ex_muldiv_iter #(.XLEN(32)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  ex_muldiv_iter #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  // Issue one request on the 32-bit unit and wait (bounded) for its strobe; lat counts
  // edges from the accepting edge (inclusive) to the edge that raised valid_o.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic we,
                        output logic [31:0] data, output int lat, output logic [4:0] tag_o,
                        output logic we_o_s, output int stall_gaps);
    logic got;
    got = 1'b0; lat = 0; stall_gaps = 0; data = 'x; tag_o = 'x; we_o_s = 1'bx;
    @(negedge clk);
    bus.op_i = op; bus.reg_1 = a; bus.reg_2 = b; bus.waddr_i = tag; bus.we_i = we;
    bus.start_i = 1'b1;
    #1 if (bus.stall_o !== 1'b1) stall_gaps++;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.start_i = 1'b0; bus.reg_1 = ~a; bus.reg_2 = a ^ b; bus.op_i = ~op;
        bus.waddr_i = ~tag; bus.we_i = ~we;
      end
      if (bus.stall_o !== 1'b1) stall_gaps++;
      if (bus.valid_o === 1'b1) begin
        got = 1'b1; data = bus.wdata_o; tag_o = bus.waddr_o; we_o_s = bus.we_o;
      end
    end
    if (!got) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start_i = 0; bus.op_i = 0; bus.reg_1 = 0; bus.reg_2 = 0; bus.waddr_i = 0;
    bus.we_i = 0; bus.flush_i = 0;
    bus16.start_i = 0; bus16.op_i = 0; bus16.reg_1 = 0; bus16.reg_2 = 0; bus16.waddr_i = 0;
    bus16.we_i = 0; bus16.flush_i = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.valid_o); else passed++;
    total++; if (bus.wdata_o !== 32'h0) $display("FAIL reset_wdata got %h exp 0", bus.wdata_o); else passed++;
    total++; if (bus.waddr_o !== 5'h0) $display("FAIL reset_waddr got %h exp 0", bus.waddr_o); else passed++;
    total++; if (bus.we_o !== 1'b0) $display("FAIL reset_we got %b exp 0", bus.we_o); else passed++;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.stall_o); else passed++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] d; int lat; logic [4:0] t; logic w; int sg;
    run_op(3'b000, 32'hFFFFFFFD, 32'h7, 5'd12, 1'b1, d, lat, t, w, sg);
    total++; if (lat != 33) $display("FAIL mul_latency got %0d exp 33", lat); else passed++;
    total++; if (d !== 32'hFFFFFFEB) $display("FAIL mul_neg3x7 got %h exp FFFFFFEB", d); else passed++;
    total++; if (t !== 5'd12) $display("FAIL mul_tag got %0d exp 12", t); else passed++;
    total++; if (w !== 1'b1) $display("FAIL mul_we got %b exp 1", w); else passed++;
    total++; if (sg != 0) $display("FAIL mul_stall_gaps got %0d exp 0", sg); else passed++;
    total++; if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.we_o !== 1'b0)
      $display("FAIL mul_after_done got stall=%b valid=%b we=%b exp 0 0 0", bus.stall_o, bus.valid_o, bus.we_o);
    else passed++;
    total++; if (bus.wdata_o !== 32'hFFFFFFEB) $display("FAIL mul_hold_wdata got %h exp FFFFFFEB", bus.wdata_o); else passed++;
    run_op(3'b001, 32'h80000000, 32'h80000000, 5'd1, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h40000000) $display("FAIL mulh_minmin got %h exp 40000000", d); else passed++;
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'hFFFFFFFE) $display("FAIL mulhu_ones got %h exp FFFFFFFE", d); else passed++;
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h00000001) $display("FAIL mul_ones got %h exp 00000001", d); else passed++;
    run_op(3'b001, 32'hFFFFFFFD, 32'h00000007, 5'd4, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'hFFFFFFFF) $display("FAIL mulh_neg got %h exp FFFFFFFF", d); else passed++;
  endtask

  task automatic test_div();
    logic [31:0] d; int lat; logic [4:0] t; logic w; int sg;
    run_op(3'b011, 32'hFFFFFFF9, 32'h2, 5'd5, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'hFFFFFFFD) $display("FAIL div_neg7_2 got %h exp FFFFFFFD", d); else passed++;
    total++; if (lat != 33) $display("FAIL div_latency got %0d exp 33", lat); else passed++;
    run_op(3'b101, 32'hFFFFFFF9, 32'h2, 5'd5, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'hFFFFFFFF) $display("FAIL rem_neg7_2 got %h exp FFFFFFFF", d); else passed++;
    run_op(3'b100, 32'hFFFFFFF9, 32'h2, 5'd6, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h7FFFFFFC) $display("FAIL divu_big got %h exp 7FFFFFFC", d); else passed++;
    run_op(3'b110, 32'hFFFFFFF9, 32'h2, 5'd6, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h00000001) $display("FAIL remu_big got %h exp 00000001", d); else passed++;
    run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h80000000) $display("FAIL div_overflow got %h exp 80000000", d); else passed++;
    run_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h00000000) $display("FAIL rem_overflow got %h exp 00000000", d); else passed++;
    run_op(3'b101, 32'h00000007, 32'hFFFFFFFE, 5'd7, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h00000001) $display("FAIL rem_pos_negdiv got %h exp 00000001", d); else passed++;
  endtask

  task automatic test_fast_path();
    logic [31:0] d; int lat; logic [4:0] t; logic w; int sg;
    run_op(3'b100, 32'h5, 32'h0, 5'd8, 1'b0, d, lat, t, w, sg);
    total++; if (lat != 1) $display("FAIL divu0_latency got %0d exp 1", lat); else passed++;
    total++; if (d !== 32'hFFFFFFFF) $display("FAIL divu0_data got %h exp FFFFFFFF", d); else passed++;
    total++; if (w !== 1'b0 || t !== 5'd8) $display("FAIL divu0_tag got we=%b tag=%0d exp we=0 tag=8", w, t); else passed++;
    run_op(3'b110, 32'h5, 32'h0, 5'd9, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h5 || lat != 1) $display("FAIL remu0 got %h lat %0d exp 5 lat 1", d, lat); else passed++;
    run_op(3'b011, 32'hFFFFFFF9, 32'h0, 5'd9, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'hFFFFFFFF) $display("FAIL div0_signed got %h exp FFFFFFFF", d); else passed++;
    run_op(3'b101, 32'hFFFFFFF9, 32'h0, 5'd9, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'hFFFFFFF9) $display("FAIL rem0_signed got %h exp FFFFFFF9", d); else passed++;
    run_op(3'b111, 32'h1234, 32'h5678, 5'd10, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'h0 || lat != 1) $display("FAIL reserved got %h lat %0d exp 0 lat 1", d, lat); else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] d; int lat; logic [4:0] t; logic w; int sg; int nvalid;
    @(negedge clk);
    bus.op_i = 3'b011; bus.reg_1 = 32'd100; bus.reg_2 = 32'd3; bus.waddr_i = 5'd9; bus.we_i = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) bus.flush_i = 1'b1;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    total++; if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0)
      $display("FAIL flush_idle got stall=%b valid=%b exp 0 0", bus.stall_o, bus.valid_o);
    else passed++;
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1 if (bus.valid_o === 1'b1) nvalid++; end
    total++; if (nvalid != 0) $display("FAIL flush_no_strobe got %0d exp 0", nvalid); else passed++;
    run_op(3'b000, 32'd6, 32'd7, 5'd3, 1'b1, d, lat, t, w, sg);
    total++; if (d !== 32'd42 || t !== 5'd3 || w !== 1'b1 || lat != 33)
      $display("FAIL after_flush_mul got %0d tag %0d we %b lat %0d exp 42 tag 3 we 1 lat 33", d, t, w, lat);
    else passed++;
    // flush arriving in the DONE cycle of a fast-path op
    @(negedge clk);
    bus.op_i = 3'b111; bus.waddr_i = 5'd11; bus.we_i = 1'b1; bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    total++; if (bus.valid_o !== 1'b1 || bus.we_o !== 1'b1)
      $display("FAIL done_pre_flush got valid=%b we=%b exp 1 1", bus.valid_o, bus.we_o);
    else passed++;
    bus.flush_i = 1'b1;
    #1;
    total++; if (bus.valid_o !== 1'b0 || bus.we_o !== 1'b0 || bus.stall_o !== 1'b1)
      $display("FAIL done_flush got valid=%b we=%b stall=%b exp 0 0 1", bus.valid_o, bus.we_o, bus.stall_o);
    else passed++;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    // flush wins over a simultaneous start
    @(negedge clk);
    bus.op_i = 3'b000; bus.reg_1 = 32'd2; bus.reg_2 = 32'd2; bus.start_i = 1'b1; bus.flush_i = 1'b1;
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL start_flush_stall got %b exp 0", bus.stall_o); else passed++;
    @(posedge clk); #1 bus.start_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL start_flush_idle got %b exp 0", bus.stall_o); else passed++;
  endtask

  task automatic test_reset_mid();
    int nvalid;
    @(negedge clk);
    bus.op_i = 3'b000; bus.reg_1 = 32'hFFFF; bus.reg_2 = 32'd3; bus.waddr_i = 5'd7; bus.we_i = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (bus.wdata_o !== 32'h0 || bus.waddr_o !== 5'h0 || bus.we_o !== 1'b0 ||
                 bus.valid_o !== 1'b0 || bus.stall_o !== 1'b0)
      $display("FAIL reset_mid got wdata=%h waddr=%0d we=%b valid=%b stall=%b exp all 0",
               bus.wdata_o, bus.waddr_o, bus.we_o, bus.valid_o, bus.stall_o);
    else passed++;
    @(negedge clk) rst = 1'b1;
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1 if (bus.valid_o === 1'b1) nvalid++; end
    total++; if (nvalid != 0) $display("FAIL reset_mid_no_strobe got %0d exp 0", nvalid); else passed++;
  endtask

  task automatic test_held_start();
    int nvalid; logic [31:0] d;
    nvalid = 0; d = 'x;
    @(negedge clk);
    bus.op_i = 3'b000; bus.reg_1 = 32'd3; bus.reg_2 = 32'd5; bus.waddr_i = 5'd4; bus.we_i = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1 bus.reg_1 = 32'd100; bus.reg_2 = 32'd100;
    repeat (45) begin
      @(posedge clk); #1;
      if (bus.valid_o === 1'b1) begin nvalid++; d = bus.wdata_o; bus.start_i = 1'b0; end
    end
    bus.start_i = 1'b0;
    total++; if (nvalid != 1) $display("FAIL held_start_strobes got %0d exp 1", nvalid); else passed++;
    total++; if (d !== 32'd15) $display("FAIL held_start_data got %0d exp 15", d); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, v1, v2, nvalid; logic [31:0] d1, d2;
    cyc = 0; v1 = -1; v2 = -1; nvalid = 0; d1 = 'x; d2 = 'x;
    @(negedge clk);
    bus.op_i = 3'b100; bus.reg_1 = 32'd100; bus.reg_2 = 32'd7; bus.waddr_i = 5'd1; bus.we_i = 1'b1;
    bus.start_i = 1'b1;
    while (nvalid < 2 && cyc < 120) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin bus.reg_1 = 32'd50; bus.reg_2 = 32'd5; end
      if (bus.valid_o === 1'b1) begin
        nvalid++;
        if (nvalid == 1) begin v1 = cyc; d1 = bus.wdata_o; end
        else begin v2 = cyc; d2 = bus.wdata_o; bus.start_i = 1'b0; end
      end
    end
    bus.start_i = 1'b0;
    total++; if (v1 != 33 || d1 !== 32'd14) $display("FAIL b2b_first got cyc %0d data %0d exp 33 14", v1, d1); else passed++;
    total++; if (v2 - v1 != 34 || v2 < 0) $display("FAIL b2b_gap got %0d exp 34", v2 - v1); else passed++;
    total++; if (d2 !== 32'd10) $display("FAIL b2b_second got %0d exp 10", d2); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_xlen16();
    int lat; logic [15:0] d; logic got;
    lat = 0; got = 1'b0; d = 'x;
    @(negedge clk);
    bus16.op_i = 3'b001; bus16.reg_1 = 16'h8000; bus16.reg_2 = 16'h8000; bus16.waddr_i = 5'd2;
    bus16.we_i = 1'b1; bus16.start_i = 1'b1;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) bus16.start_i = 1'b0;
      if (bus16.valid_o === 1'b1) begin got = 1'b1; d = bus16.wdata_o; end
    end
    total++; if (lat != 17 || !got) $display("FAIL x16_latency got %0d exp 17", lat); else passed++;
    total++; if (d !== 16'h4000) $display("FAIL x16_mulh got %h exp 4000", d); else passed++;
    @(posedge clk); #1;
    got = 1'b0; lat = 0;
    @(negedge clk);
    bus16.op_i = 3'b101; bus16.reg_1 = 16'hFFF9; bus16.reg_2 = 16'h0002; bus16.start_i = 1'b1;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) bus16.start_i = 1'b0;
      if (bus16.valid_o === 1'b1) begin got = 1'b1; d = bus16.wdata_o; end
    end
    total++; if (d !== 16'hFFFF) $display("FAIL x16_rem got %h exp FFFF", d); else passed++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_reset_mid();
    test_held_start();
    test_back_to_back();
    test_xlen16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
